stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Sequencing controller for the stopwatch display path. It owns the four binary time counters: centiseconds `ptgiay`, seconds `giay`, minutes `phut` and hours `gio`. It runs them from the system clock through a 1/100 s prescaler and handles the start/stop, clear and lap (split) controls. Its four 7-bit outputs drive the hex-to-BCD display converter directly.

## Interface
- `CLK_HZ`, default 100_000_000: system clock frequency. `DIV = CLK_HZ/100` clocks per centisecond. `CLK_HZ` must be a multiple of 100 and at least 200.
- `clk` input, 1 bit: system clock, rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `btn_ss` input, 1 bit: start/stop. One-cycle pulse, already debounced.
- `btn_clr` input, 1 bit: clear. One-cycle pulse.
- `btn_lap` input, 1 bit: lap/split toggle. One-cycle pulse.
- `ptgiay` output, 7 bits: displayed centiseconds, 0..99.
- `giay` output, 7 bits: displayed seconds, 0..59.
- `phut` output, 7 bits: displayed minutes, 0..59.
- `gio` output, 7 bits: displayed hours, 0..99.
- `running` output, 1 bit: high in RUN and LAP.
- `lap_hold` output, 1 bit: high while the display is frozen (LAP).
- `overflow` output, 1 bit: high in FULL.

## Operation
- **Live counters.** `cs`, `s`, `m`, `h`, each 7 bits binary.
- **Prescaler.** `pre` counts 0..DIV-1. `tick` = (`pre` == DIV-1) and the state is RUN or LAP.
- **Increment on tick.**
  - `cs` wraps 99→0 and carries to `s`.
  - `s` wraps 59→0 and carries to `m`.
  - `m` wraps 59→0 and carries to `h`.
  - `h` saturates: a tick at 99:59:59.99 leaves all counters at their maximum and enters FULL.
- **Prescaler behaviour by state.** Advances in RUN/LAP, holds its value in PAUSE and FULL, is 0 in IDLE.
- **Display mux.** Outputs equal the lap registers while `lap_hold` = 1, otherwise the live counters. The mux is combinational from registers; there is no pipeline.
- **States.** IDLE, RUN, LAP, PAUSE, FULL.
- **Transitions.** Input priority per cycle is `btn_clr` > `btn_ss` > `btn_lap`; a lower-priority pulse in the same cycle is dropped.
  - IDLE: `btn_ss` → RUN. `btn_lap` is ignored.
  - RUN: `btn_ss` → PAUSE. `btn_lap` → LAP and captures the live counters into the lap registers (the post-tick value if a tick occurs in the same cycle).
  - LAP: counting continues. `btn_lap` → RUN and the display releases. `btn_ss` → PAUSE and the display releases.
  - PAUSE: `btn_ss` → RUN, resuming from the held prescaler value. `btn_lap` is ignored.
  - FULL: `btn_ss` and `btn_lap` are ignored, `lap_hold` = 0.
  - Any state: `btn_clr` → IDLE. Counters, prescaler and lap registers clear to 0, and any tick in that cycle is discarded.
- **Tick coincident with `btn_ss` in RUN/LAP.** The increment is applied, then the state goes to PAUSE.

## Timing
- **Reset.** Takes effect on the first rising edge with `rst` = 1.
  - State IDLE; all counters, prescaler and lap registers 0.
  - Outputs after reset: `ptgiay`/`giay`/`phut`/`gio` = 0; `running`, `lap_hold`, `overflow` = 0.
- **Reset mid-operation.** Behaves identically to reset from any state and overrides all buttons.
- **First increment.** Start pulse at edge N gives `running` = 1 after edge N. The first `cs` increment is visible after edge N+DIV.
- **Lap capture.** `lap_hold` rises and the display freezes after the edge that samples `btn_lap`. Live counting never loses a tick.
- **Throughput.** One increment per DIV clocks, with no drift.

## Configuration
- Macro `STOPWATCH_LAP_EN`.
  - Defined: LAP state, lap registers and `btn_lap` handling as specified above.
  - Undefined: the LAP state and lap registers are not built, `btn_lap` is ignored, and `lap_hold` is tied to 0. All other behaviour is unchanged.

## Test plan
All scenarios use `CLK_HZ` = 400 (DIV = 4) and `STOPWATCH_LAP_EN` defined unless noted.

- **Start, count, stop.** Reset, `btn_ss` pulse, run 4×100 clocks, then `btn_ss`. Outputs read 00:00:01.00 with `running` = 0. After a further 40 clocks the outputs are unchanged.
- **Carry chain.** Force the live time to 00:59:59.99 in RUN and wait one tick. Outputs read 01:00:00.00; the next tick gives 01:00:00.01.
- **Lap freeze.** In RUN at 00:00:00.10, pulse `btn_lap`, then wait 20 ticks. Display holds 00:00:00.10 with `lap_hold` = 1. After a second `btn_lap`, the display shows 00:00:00.30.
- **Saturation.** Set the time to 99:59:59.99 in RUN and wait one tick. `overflow` = 1 and outputs stay at 99:59:59.99. `btn_ss` has no effect; `btn_clr` gives all zeros, IDLE and `overflow` = 0.
- **Simultaneous buttons.** In RUN, `btn_clr` and `btn_ss` in the same cycle give IDLE with zero outputs. In RUN, `btn_ss` and `btn_lap` together give PAUSE with `lap_hold` = 0.
- **Macro off and reset mid-run.** With `STOPWATCH_LAP_EN` undefined, `btn_lap` in RUN leaves `lap_hold` = 0 and counting continues. Asserting `rst` mid-run zeroes all outputs on the next edge.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: prescaled cs/s/m/h stopwatch with start/stop, clear and lap (lap logic built only when STOPWATCH_LAP_EN is defined)
module stopwatch_ctrl #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_clr,
  input  logic       btn_lap,
  output logic [6:0] ptgiay,
  output logic [6:0] giay,
  output logic [6:0] phut,
  output logic [6:0] gio,
  output logic       running,
  output logic       lap_hold,
  output logic       overflow
);
  localparam int DIV = CLK_HZ / 100;
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  typedef enum logic [2:0] {IDLE, RUN, LAP, PAUSE, FULL} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [6:0] cs_q, s_q, m_q, h_q, cs_d, s_d, m_d, h_d;
  logic run_q, ovf_q;
  logic act, tick, at_max, inc, c_cs, c_s, c_m;
  always_comb begin
    act = state_q == RUN || state_q == LAP;
    tick = act && pre_q == PW'(DIV - 1);
    c_cs = cs_q == 7'd99;
    c_s = c_cs && s_q == 7'd59;
    c_m = c_s && m_q == 7'd59;
    at_max = c_m && h_q == 7'd99;
    inc = tick && !at_max;
    pre_d = !act ? pre_q : tick ? '0 : pre_q + 1'b1;
    cs_d = inc ? (c_cs ? 7'd0 : cs_q + 7'd1) : cs_q;
    s_d = inc && c_cs ? (c_s ? 7'd0 : s_q + 7'd1) : s_q;
    m_d = inc && c_s ? (c_m ? 7'd0 : m_q + 7'd1) : m_q;
    h_d = inc && c_m ? h_q + 7'd1 : h_q;
    state_d = state_q;
    if (btn_clr) state_d = IDLE;
    else if (tick && at_max) state_d = FULL;
    else if (btn_ss) state_d = (state_q == IDLE || state_q == PAUSE) ? RUN : act ? PAUSE : state_q;
`ifdef STOPWATCH_LAP_EN
    else if (btn_lap) state_d = state_q == RUN ? LAP : state_q == LAP ? RUN : state_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst || btn_clr) begin
      state_q <= IDLE;
      pre_q <= '0;
      {cs_q, s_q, m_q, h_q} <= '0;
      run_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q <= pre_d;
      {cs_q, s_q, m_q, h_q} <= {cs_d, s_d, m_d, h_d};
      run_q <= state_d == RUN || state_d == LAP;
      ovf_q <= state_d == FULL;
    end
  end
  assign running = run_q;
  assign overflow = ovf_q;
`ifdef STOPWATCH_LAP_EN
  logic [6:0] lcs_q, ls_q, lm_q, lh_q;
  logic hold_q;
  // Capture the post-tick value so the frozen display matches the live time at the press
  always_ff @(posedge clk) begin
    if (rst || btn_clr) begin
      {lcs_q, ls_q, lm_q, lh_q} <= '0;
      hold_q <= 1'b0;
    end else begin
      if (state_q == RUN && state_d == LAP) {lcs_q, ls_q, lm_q, lh_q} <= {cs_d, s_d, m_d, h_d};
      hold_q <= state_d == LAP;
    end
  end
  assign lap_hold = hold_q;
  assign ptgiay = hold_q ? lcs_q : cs_q;
  assign giay = hold_q ? ls_q : s_q;
  assign phut = hold_q ? lm_q : m_q;
  assign gio = hold_q ? lh_q : h_q;
`else
  logic unused_lap;
  assign unused_lap = btn_lap;
  assign lap_hold = 1'b0;
  assign ptgiay = cs_q;
  assign giay = s_q;
  assign phut = m_q;
  assign gio = h_q;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: table-driven and directed checks of stopwatch_ctrl at CLK_HZ=400 (DIV=4)
module tb_stopwatch_ctrl;
  logic clk = 1'b0;
  logic rst, btn_ss, btn_clr, btn_lap;
  logic [6:0] ptgiay, giay, phut, gio;
  logic running, lap_hold, overflow;
  int checks = 0;
  int errors = 0;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif
  stopwatch_ctrl #(.CLK_HZ(400)) dut (
    .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_clr(btn_clr), .btn_lap(btn_lap),
    .ptgiay(ptgiay), .giay(giay), .phut(phut), .gio(gio),
    .running(running), .lap_hold(lap_hold), .overflow(overflow)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic ss, clr, lap;
    int idle;
    logic [6:0] h, m, s, cs;
    logic r, l, o;
  } vec_t;
  vec_t v[20];
  function automatic vec_t mk(logic ss, logic clr, logic lap, int idle,
                              logic [6:0] h, logic [6:0] m, logic [6:0] s, logic [6:0] cs,
                              logic r, logic l, logic o);
    vec_t x;
    x.ss = ss; x.clr = clr; x.lap = lap; x.idle = idle;
    x.h = h; x.m = m; x.s = s; x.cs = cs; x.r = r; x.l = l; x.o = o;
    return x;
  endfunction
  task automatic check(string name, logic [6:0] h, logic [6:0] m, logic [6:0] s, logic [6:0] cs,
                       logic r, logic l, logic o);
    checks++;
    if ({gio, phut, giay, ptgiay, running, lap_hold, overflow} !== {h, m, s, cs, r, l, o}) begin
      errors++;
      $display("FAIL %s: got %0d:%0d:%0d.%0d run=%b hold=%b ovf=%b, expected %0d:%0d:%0d.%0d run=%b hold=%b ovf=%b",
               name, gio, phut, giay, ptgiay, running, lap_hold, overflow, h, m, s, cs, r, l, o);
    end
  endtask
  task automatic apply(logic ss, logic clr, logic lap, int idle);
    btn_ss = ss; btn_clr = clr; btn_lap = lap;
    @(negedge clk);
    btn_ss = 1'b0; btn_clr = 1'b0; btn_lap = 1'b0;
    repeat (idle) @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic preset(logic [6:0] h, logic [6:0] m, logic [6:0] s, logic [6:0] cs);
    dut.h_q <= h; dut.m_q <= m; dut.s_q <= s; dut.cs_q <= cs;
    #1;
  endtask
  initial begin
    rst = 1'b0; btn_ss = 1'b0; btn_clr = 1'b0; btn_lap = 1'b0;
    v[0]  = mk(0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0);
    v[1]  = mk(1, 0, 0, 0,   0, 0, 0, 0,  1, 0, 0);
    v[2]  = mk(0, 0, 0, 398, 0, 0, 0, 99, 1, 0, 0);
    v[3]  = mk(1, 0, 0, 0,   0, 0, 1, 0,  0, 0, 0);
    v[4]  = mk(0, 0, 0, 39,  0, 0, 1, 0,  0, 0, 0);
    v[5]  = mk(1, 0, 0, 0,   0, 0, 1, 0,  1, 0, 0);
    v[6]  = mk(0, 0, 0, 2,   0, 0, 1, 0,  1, 0, 0);
    v[7]  = mk(0, 0, 0, 0,   0, 0, 1, 1,  1, 0, 0);
    v[8]  = mk(0, 0, 0, 1,   0, 0, 1, 1,  1, 0, 0);
    v[9]  = mk(1, 0, 0, 0,   0, 0, 1, 1,  0, 0, 0);
    v[10] = mk(0, 0, 0, 9,   0, 0, 1, 1,  0, 0, 0);
    v[11] = mk(1, 0, 0, 0,   0, 0, 1, 1,  1, 0, 0);
    v[12] = mk(0, 0, 0, 0,   0, 0, 1, 2,  1, 0, 0);
    v[13] = mk(0, 0, 1, 0,   0, 0, 1, 2,  1, LAP_EN, 0);
    v[14] = mk(0, 0, 0, 79,  0, 0, 1, LAP_EN ? 7'd2 : 7'd22, 1, LAP_EN, 0);
    v[15] = mk(0, 0, 1, 0,   0, 0, 1, 22, 1, 0, 0);
    v[16] = mk(1, 0, 1, 0,   0, 0, 1, 22, 0, 0, 0);
    v[17] = mk(1, 0, 0, 0,   0, 0, 1, 22, 1, 0, 0);
    v[18] = mk(1, 1, 0, 0,   0, 0, 0, 0,  0, 0, 0);
    v[19] = mk(0, 0, 1, 3,   0, 0, 0, 0,  0, 0, 0);
    @(negedge clk);
    do_reset();
    check("reset", 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      apply(v[i].ss, v[i].clr, v[i].lap, v[i].idle);
      check($sformatf("vec%0d", i), v[i].h, v[i].m, v[i].s, v[i].cs, v[i].r, v[i].l, v[i].o);
    end
    do_reset();
    apply(1, 0, 0, 0);
    preset(0, 59, 59, 99);
    repeat (4) @(negedge clk);
    check("carry", 1, 0, 0, 0, 1, 0, 0);
    repeat (4) @(negedge clk);
    check("carry_next", 1, 0, 0, 1, 1, 0, 0);
    do_reset();
    apply(1, 0, 0, 0);
    preset(99, 59, 59, 99);
    repeat (4) @(negedge clk);
    check("saturate", 99, 59, 59, 99, 0, 0, 1);
    apply(1, 0, 1, 7);
    check("full_ignores_ss", 99, 59, 59, 99, 0, 0, 1);
    apply(0, 1, 0, 0);
    check("full_clear", 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    apply(1, 0, 0, 3);
`ifdef STOPWATCH_LAP_EN
    apply(0, 0, 1, 0);
    check("lap_on_tick", 0, 0, 0, 1, 1, 1, 0);
    repeat (4) @(negedge clk);
    check("lap_frozen", 0, 0, 0, 1, 1, 1, 0);
    apply(0, 0, 1, 0);
    check("lap_release", 0, 0, 0, 2, 1, 0, 0);
`else
    apply(0, 0, 1, 0);
    check("nolap_tick", 0, 0, 0, 1, 1, 0, 0);
    repeat (4) @(negedge clk);
    check("nolap_counts", 0, 0, 0, 2, 1, 0, 0);
`endif
    do_reset();
    apply(1, 0, 0, 9);
    check("pre_rst_run", 0, 0, 0, 2, 1, 0, 0);
    rst = 1'b1; btn_ss = 1'b1; btn_lap = 1'b1;
    @(negedge clk);
    rst = 1'b0; btn_ss = 1'b0; btn_lap = 1'b0;
    check("rst_mid_run", 0, 0, 0, 0, 0, 0, 0);
    repeat (8) @(negedge clk);
    check("rst_idle", 0, 0, 0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
